l1_prefetch_responder: RTL and testbench
========================================

Name: l1_prefetch_responder

Overview:
- Responder on the L1 cache's physical-memory line interface, and initiator toward physical memory or L2.
- Forwards L1 line reads and writes.
- After each L1 read miss, prefetches the next line into a one-line buffer, using the L1 peek port to skip lines the L1 already holds.
- Drives lockout so the L1 cannot start a miss while a prefetch is being decided or filled.

Parameters:
PF_ENABLE, 1, 1 = prefetch after reads; 0 = pure pass-through responder.
PF_STRIDE, 1, line-index increment for the prefetch target (1..15).

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
l1_address  in  16  L1 line request address; bits [3:0] ignored
l1_wdata  in  128  L1 writeback line
l1_read  in  1  L1 line read request (level, held until l1_resp)
l1_write  in  1  L1 line write request (level, held until l1_resp)
l1_rdata  out  128  returned line, registered
l1_resp  out  1  one-cycle completion pulse to L1
lockout  out  1  holds L1 control in idle
peek_address  out  16  address probed in L1 tags
peek_hit  in  1  combinational L1 hit for peek_address
mem_address  out  16  line address to memory, {tag,4'b0}
mem_wdata  out  128  line to memory
mem_read  out  1  memory read request (level)
mem_write  out  1  memory write request (level)
mem_rdata  in  128  memory line data, valid with mem_resp
mem_resp  in  1  memory completion pulse

Behaviour:
- Reset (async): state IDLE, pf_valid=0, pf_tag=0, l1_rdata=0. All other outputs 0.
- Handshake, both sides: the request stays asserted with a stable address and data until a one-cycle resp. The requester may drop or re-issue its request the cycle after resp.
- mem_read, mem_write, mem_address, mem_wdata, peek_address and lockout are Moore outputs, decoded from state and registers.
- Internal registers: req_tag[11:0], pf_tag[11:0], pf_valid, pf_buf[127:0], pf_next[11:0].
- State machine:
  - IDLE:
    - l1_write (priority if both requests asserted): latch tag; if pf_valid and tag==pf_tag then clear pf_valid. Go to WR.
    - Else l1_read with pf_valid and tag==pf_tag: l1_rdata<=pf_buf, pf_valid<=0. Go to RESP_RD.
    - Else l1_read: go to RD.
    - mem_resp in IDLE is ignored.
  - RD: mem_read=1, mem_address={req_tag,4'b0}. On mem_resp: l1_rdata<=mem_rdata, go to RESP_RD.
  - WR: mem_write=1, mem_wdata=l1_wdata. On mem_resp go to RESP_WR.
  - RESP_RD: l1_resp=1 for exactly one cycle. pf_next<=req_tag+PF_STRIDE.
    - If PF_ENABLE and no carry out of bit 11, go to PF_CHECK.
    - Otherwise (wrap past 0xFFF) go to IDLE; no prefetch.
  - RESP_WR: l1_resp=1 for one cycle, then go to IDLE. No prefetch after writes.
  - PF_CHECK: lockout=1, peek_address={pf_next,4'b0}. peek_hit is sampled this cycle.
    - peek_hit=1 → IDLE.
    - Else if pf_valid and pf_tag==pf_next → IDLE.
    - Else → PF_FETCH.
  - PF_FETCH: lockout=1, mem_read=1, mem_address={pf_next,4'b0}.
    - On mem_resp: pf_buf<=mem_rdata, pf_tag<=pf_next, pf_valid<=1. Go to IDLE.
    - An L1 request that arrives here stays pending and is served from IDLE; a read of pf_next then hits the buffer.
- Latency:
  - Buffer hit: l1_resp 2 cycles after the request is seen in IDLE.
  - Miss: l1_resp 1 cycle after mem_resp.
- Prefetch overwrites any older buffered line; there is a single buffer entry.
- l1_rdata holds its value between responses.
- Reset asserted mid-transaction aborts to IDLE with the buffer invalid. No pending resp is ever issued.

Test Plan:
- Reset, then read 0x1230 with mem_resp after 3 cycles, data A → l1_resp one cycle later, l1_rdata=A. Then PF_CHECK with peek_address=0x1240, lockout=1.
- Continue with peek_hit=0, mem returns B → mem_read at 0x1240, pf_valid=1. L1 read 0x1240 → l1_resp in 2 cycles with data B and no mem_read.
- Read miss at 0x5670 with peek_hit=1 in PF_CHECK → no memory access at 0x5680; lockout=0 the next cycle.
- Buffer holds 0x1240, then L1 write 0x1240 data C → pf_valid cleared, mem_write with C, one l1_resp. A subsequent read of 0x1240 goes to memory.
- Read 0xFFF0 → response, then IDLE with no prefetch. l1_read and l1_write asserted together → write serviced first.
- Assert reset during PF_FETCH → all outputs 0 immediately, pf_valid=0. A later mem_resp is ignored.

Source files
------------

// File: rtl/l1_prefetch_responder.sv
// L1 line-interface responder with a single-entry next-line prefetch buffer.
// Forwards L1 reads/writes to memory and prefetches req_tag+PF_STRIDE after read misses and buffer hits.
module l1_prefetch_responder #(
  parameter int unsigned PF_ENABLE = 1,
  parameter int unsigned PF_STRIDE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  l1_address,
  input  logic [127:0] l1_wdata,
  input  logic         l1_read,
  input  logic         l1_write,
  output logic [127:0] l1_rdata,
  output logic         l1_resp,
  output logic         lockout,
  output logic [15:0]  peek_address,
  input  logic         peek_hit,
  output logic [15:0]  mem_address,
  output logic [127:0] mem_wdata,
  output logic         mem_read,
  output logic         mem_write,
  input  logic [127:0] mem_rdata,
  input  logic         mem_resp
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD       = 3'd1;
  localparam logic [2:0] WR       = 3'd2;
  localparam logic [2:0] RESP_RD  = 3'd3;
  localparam logic [2:0] RESP_WR  = 3'd4;
  localparam logic [2:0] PF_CHECK = 3'd5;
  localparam logic [2:0] PF_FETCH = 3'd6;

  logic [2:0]   state;
  logic [11:0]  req_tag;
  logic [11:0]  pf_tag;
  logic [11:0]  pf_next;
  logic         pf_valid;
  logic [127:0] pf_buf;

  logic [11:0]  l1_tag;
  logic [12:0]  next_sum;
  logic         tag_hit;
  logic         offset_unused;

  assign l1_tag        = l1_address[15:4];
  assign offset_unused = ^l1_address[3:0];
  assign tag_hit       = pf_valid && (l1_tag == pf_tag);
  // Bit 12 is the carry out of the line index; a wrapped target is never prefetched.
  assign next_sum      = {1'b0, req_tag} + 13'(PF_STRIDE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      req_tag  <= '0;
      pf_tag   <= '0;
      pf_next  <= '0;
      pf_valid <= 1'b0;
      pf_buf   <= '0;
      l1_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (l1_write) begin
            req_tag <= l1_tag;
            if (tag_hit) pf_valid <= 1'b0;
            state <= WR;
          end else if (l1_read) begin
            req_tag <= l1_tag;
            if (tag_hit) begin
              l1_rdata <= pf_buf;
              pf_valid <= 1'b0;
              state    <= RESP_RD;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (mem_resp) begin
            l1_rdata <= mem_rdata;
            state    <= RESP_RD;
          end
        end
        WR: begin
          if (mem_resp) state <= RESP_WR;
        end
        RESP_RD: begin
          pf_next <= next_sum[11:0];
          state   <= ((PF_ENABLE != 0) && !next_sum[12]) ? PF_CHECK : IDLE;
        end
        RESP_WR: state <= IDLE;
        PF_CHECK: begin
          if (peek_hit || (pf_valid && (pf_tag == pf_next))) state <= IDLE;
          else state <= PF_FETCH;
        end
        PF_FETCH: begin
          if (mem_resp) begin
            pf_buf   <= mem_rdata;
            pf_tag   <= pf_next;
            pf_valid <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    l1_resp      = (state == RESP_RD) || (state == RESP_WR);
    lockout      = (state == PF_CHECK) || (state == PF_FETCH);
    peek_address = (state == PF_CHECK) ? {pf_next, 4'h0} : '0;
    mem_read     = (state == RD) || (state == PF_FETCH);
    mem_write    = (state == WR);
    mem_wdata    = (state == WR) ? l1_wdata : '0;
    mem_address  = '0;
    case (state)
      RD, WR:   mem_address = {req_tag, 4'h0};
      PF_FETCH: mem_address = {pf_next, 4'h0};
      default:  mem_address = '0;
    endcase
  end

endmodule

// File: tb/tb_l1_prefetch_responder.sv
// Directed bench for l1_prefetch_responder: vector table of L1 transactions plus hand sequences
// for a request pending during prefetch and reset during a prefetch fill.
module tb_l1_prefetch_responder;

  localparam int unsigned STRIDE = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  l1_address;
  logic [127:0] l1_wdata;
  logic         l1_read;
  logic         l1_write;
  logic [127:0] l1_rdata;
  logic         l1_resp;
  logic         lockout;
  logic [15:0]  peek_address;
  logic         pk;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic         mem_read;
  logic         mem_write;
  logic [127:0] mem_rdata;
  logic         mem_resp;

  l1_prefetch_responder #(.PF_ENABLE(1), .PF_STRIDE(STRIDE)) dut (
    .clk(clk), .reset(reset),
    .l1_address(l1_address), .l1_wdata(l1_wdata), .l1_read(l1_read), .l1_write(l1_write),
    .l1_rdata(l1_rdata), .l1_resp(l1_resp), .lockout(lockout),
    .peek_address(peek_address), .peek_hit(pk),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  // Memory model: fixed latency, one-cycle resp pulse, access log.
  typedef struct packed { logic we; logic [15:0] a; } acc_t;
  acc_t         log_q[$];
  logic [127:0] store [logic [15:0]];
  int           mem_lat = 1;
  int           cnt = 0;
  int unsigned  resp_cyc = 0;
  logic         stray = 1'b0;

  function automatic logic [127:0] pat(input logic [15:0] a);
    return {4{16'hC0DE ^ a, a}};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      cnt = 0;
      mem_resp = 1'b0;
    end else if (mem_resp) begin
      mem_resp = 1'b0;
    end else if (mem_read || mem_write) begin
      cnt++;
      if (cnt >= mem_lat) begin
        cnt = 0;
        mem_resp = 1'b1;
        resp_cyc = cyc;
        if (mem_write) store[mem_address] = mem_wdata;
        else mem_rdata = store.exists(mem_address) ? store[mem_address] : pat(mem_address);
        log_q.push_back({mem_write, mem_address});
      end
    end
    if (stray) begin
      mem_resp  = 1'b1;
      mem_rdata = '1;
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chka(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chkb(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chki(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_resp(output logic got, output int unsigned at);
    got = 1'b0;
    at  = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk); #1;
      if (l1_resp) begin
        got = 1'b1;
        at  = cyc;
      end
    end
    chkb("resp_seen", got, 1'b1);
  endtask

  task automatic settle();
    for (int n = 0; n < 200 && lockout; n++) begin
      @(negedge clk); #1;
    end
    chkb("settle_lockout", lockout, 1'b0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_l1_rdata"}, l1_rdata, '0);
    chkb({tag, "_l1_resp"}, l1_resp, 1'b0);
    chkb({tag, "_lockout"}, lockout, 1'b0);
    chka({tag, "_peek_address"}, peek_address, 16'h0);
    chka({tag, "_mem_address"}, mem_address, 16'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, '0);
    chkb({tag, "_mem_read"}, mem_read, 1'b0);
    chkb({tag, "_mem_write"}, mem_write, 1'b0);
  endtask

  typedef struct {
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    int           lat;
    logic         pk;
    logic [127:0] exp_rdata;
    logic         exp_mem;
    logic         exp_chk;
    logic         exp_pf;
    logic [15:0]  pf_addr;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                              input logic [127:0] wdata, input int lat, input logic p,
                              input logic [127:0] exp_rdata, input logic exp_mem,
                              input logic exp_chk, input logic exp_pf, input logic [15:0] pf_addr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.lat = lat; v.pk = p;
    v.exp_rdata = exp_rdata; v.exp_mem = exp_mem; v.exp_chk = exp_chk;
    v.exp_pf = exp_pf; v.pf_addr = pf_addr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic        got;
    int unsigned at;
    int unsigned t0;
    int          ne;
    int          idx;
    pk = v.pk;
    mem_lat = v.lat;
    log_q.delete();
    l1_address = v.addr;
    l1_wdata   = v.wdata;
    l1_read    = v.rd;
    l1_write   = v.wr;
    t0 = cyc;
    wait_resp(got, at);
    l1_read  = 1'b0;
    l1_write = 1'b0;
    if (got) begin
      if (!v.wr) chk("l1_rdata", l1_rdata, v.exp_rdata);
      if (v.exp_mem) chki("miss_latency", int'(at - resp_cyc), 1);
      else chki("hit_latency", int'(at - t0 + 1), 2);
    end
    @(negedge clk); #1;
    chkb("resp_one_cycle", l1_resp, 1'b0);
    chkb("check_lockout", lockout, v.exp_chk);
    if (v.exp_chk) begin
      chka("peek_address", peek_address, v.pf_addr);
      @(negedge clk); #1;
      chkb("fetch_lockout", lockout, v.exp_pf);
    end
    settle();
    ne = 0;
    if (v.exp_mem) ne++;
    if (v.exp_pf) ne++;
    chki("mem_access_count", log_q.size(), ne);
    if (log_q.size() == ne) begin
      idx = 0;
      if (v.exp_mem) begin
        chkb("mem_we", log_q[0].we, v.wr);
        chka("mem_addr", log_q[0].a, v.addr);
        idx = 1;
      end
      if (v.exp_pf) begin
        chkb("pf_we", log_q[idx].we, 1'b0);
        chka("pf_addr", log_q[idx].a, v.pf_addr);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic        got;
    int unsigned at;
    logic [127:0] dc;
    logic [127:0] cdat;
    logic [127:0] ddat;
    dc   = '0;
    cdat = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    ddat = {4{32'hDEAD_BEEF}};

    //          rd    wr    addr      wdata lat pk    exp_rdata        mem   chk   pf    pf_addr
    vecs.push_back(mk(1'b1, 1'b0, 16'h1230, dc,   3, 1'b0, pat(16'h1230), 1'b1, 1'b1, 1'b1, 16'h1240));
    vecs.push_back(mk(1'b1, 1'b0, 16'h1240, dc,   1, 1'b0, pat(16'h1240), 1'b0, 1'b1, 1'b1, 16'h1250));
    vecs.push_back(mk(1'b1, 1'b0, 16'h5670, dc,   2, 1'b1, pat(16'h5670), 1'b1, 1'b1, 1'b0, 16'h5680));
    vecs.push_back(mk(1'b1, 1'b0, 16'h1230, dc,   2, 1'b0, pat(16'h1230), 1'b1, 1'b1, 1'b1, 16'h1240));
    vecs.push_back(mk(1'b0, 1'b1, 16'h1240, cdat, 2, 1'b0, dc,            1'b1, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(1'b1, 1'b0, 16'h1240, dc,   1, 1'b0, cdat,          1'b1, 1'b1, 1'b1, 16'h1250));
    vecs.push_back(mk(1'b1, 1'b0, 16'h1250, dc,   1, 1'b1, pat(16'h1250), 1'b0, 1'b1, 1'b0, 16'h1260));
    vecs.push_back(mk(1'b1, 1'b0, 16'hFFF0, dc,   1, 1'b0, pat(16'hFFF0), 1'b1, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(1'b1, 1'b1, 16'h2000, ddat, 2, 1'b0, dc,            1'b1, 1'b0, 1'b0, 16'h0000));
    vecs.push_back(mk(1'b1, 1'b0, 16'h2000, dc,   1, 1'b0, ddat,          1'b1, 1'b1, 1'b1, 16'h2010));
    vecs.push_back(mk(1'b1, 1'b0, 16'h2400, dc,   1, 1'b0, pat(16'h2400), 1'b1, 1'b1, 1'b1, 16'h2410));
    vecs.push_back(mk(1'b1, 1'b0, 16'h2400, dc,   1, 1'b0, pat(16'h2400), 1'b1, 1'b1, 1'b0, 16'h2410));
    vecs.push_back(mk(1'b1, 1'b0, 16'h2410, dc,   1, 1'b0, pat(16'h2410), 1'b0, 1'b1, 1'b1, 16'h2420));

    reset = 1'b1;
    l1_address = '0; l1_wdata = '0; l1_read = 1'b0; l1_write = 1'b0;
    pk = 1'b0; mem_rdata = '0; mem_resp = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Read arriving during PF_CHECK/PF_FETCH waits and then hits the freshly filled buffer.
    log_q.delete();
    mem_lat = 4; pk = 1'b0;
    l1_address = 16'h4000; l1_read = 1'b1;
    wait_resp(got, at);
    l1_read = 1'b0;
    chk("pend_first_rdata", l1_rdata, pat(16'h4000));
    @(negedge clk); #1;
    chkb("pend_in_check", lockout, 1'b1);
    l1_address = 16'h4010; l1_read = 1'b1;
    wait_resp(got, at);
    l1_read = 1'b0;
    chk("pend_hit_rdata", l1_rdata, pat(16'h4010));
    chki("pend_access_count", log_q.size(), 2);
    if (log_q.size() == 2) chka("pend_pf_addr", log_q[1].a, 16'h4010);
    @(negedge clk); #1;
    settle();

    // Reset in the middle of a prefetch fill, then a stray mem_resp in IDLE.
    log_q.delete();
    mem_lat = 2; pk = 1'b0;
    l1_address = 16'h3000; l1_read = 1'b1;
    wait_resp(got, at);
    l1_read = 1'b0;
    mem_lat = 20;
    for (int n = 0; n < 50 && !(lockout && mem_read); n++) begin
      @(negedge clk); #1;
    end
    chkb("reach_pf_fetch", lockout && mem_read, 1'b1);
    chka("pf_fetch_addr", mem_address, 16'h3010);
    reset = 1'b1;
    #1;
    chk_idle_outputs("abort");
    @(negedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    stray = 1'b1;
    @(negedge clk); #1;
    stray = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); #1;
      chkb("stray_mem_read", mem_read, 1'b0);
      chkb("stray_l1_resp", l1_resp, 1'b0);
      chk("stray_l1_rdata", l1_rdata, '0);
    end
    run_vec(mk(1'b1, 1'b0, 16'h2420, dc, 1, 1'b1, pat(16'h2420), 1'b1, 1'b1, 1'b0, 16'h2430));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
